// File: rtl/btn_conditioner_pkg.sv
// Shared types for the front-panel button conditioner: channel FSM states and tick divider helper.
// Latency: n/a (declarations only); no backpressure.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESSED   = 2'b01,
    LONG_HELD = 2'b10
  } btn_state_t;

  // CLK cycles per millisecond tick.
  function automatic int tick_div(input int clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, tick-based debouncer and press/release/short/long event FSM.
// Latency: 2 cycles sync + DEBOUNCE_MS ticks; events registered with the level flip; no backpressure.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 3000
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic raw,
  output logic lvl,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic hold
);

  localparam int DBW = $clog2(DEBOUNCE_MS) + 1;
  localparam int HCW = $clog2(LONG_MS);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_MS - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(LONG_MS - 1);

  logic           sync1;
  logic           sync2;
  logic [DBW-1:0] db_cnt;
  logic [HCW-1:0] hold_cnt;
  btn_state_t     state;
  logic           flip;
  logic           rise;
  logic           fall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The FSM reacts to the flip on the same edge the level register changes.
  assign flip = tick && (sync2 != lvl) && (db_cnt == DB_LAST);
  assign rise = flip && sync2;
  assign fall = flip && !sync2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lvl    <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 == lvl) begin
      db_cnt <= '0;
    end else if (tick) begin
      if (flip) begin
        lvl    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      hold          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
            state       <= PRESSED;
          end
        end
        PRESSED: begin
          // Release takes priority over a long threshold reached on the same tick.
          if (fall) begin
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            state         <= IDLE;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              long_pulse <= 1'b1;
              hold       <= 1'b1;
              state      <= LONG_HELD;
            end else begin
              hold_cnt <= hold_cnt + HCW'(1);
            end
          end
        end
        LONG_HELD: begin
          if (fall) begin
            release_pulse <= 1'b1;
            hold          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner with a shared 1 ms tick; clean single-cycle button events.
// Latency: 2 cycles sync + DEBOUNCE_MS ticks to level/press; no backpressure (pulses are fire-and-forget).
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int CLK_FREQ    = 125_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 3000,
  parameter int N_BTN       = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_RAW,
  output logic [N_BTN-1:0] BTN_LVL,
  output logic [N_BTN-1:0] PRESS_PULSE,
  output logic [N_BTN-1:0] RELEASE_PULSE,
  output logic [N_BTN-1:0] SHORT_PULSE,
  output logic [N_BTN-1:0] LONG_PULSE,
  output logic [N_BTN-1:0] HOLD,
  output logic             TICK_MS
);

  localparam int TICK_DIV = tick_div(CLK_FREQ);
  localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

  logic [TCW-1:0] tick_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt <= '0;
      TICK_MS  <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      TICK_MS  <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TCW'(1);
      TICK_MS  <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_ch (
      .CLK           (CLK),
      .RST           (RST),
      .tick          (TICK_MS),
      .raw           (BTN_RAW[g]),
      .lvl           (BTN_LVL[g]),
      .press_pulse   (PRESS_PULSE[g]),
      .release_pulse (RELEASE_PULSE[g]),
      .short_pulse   (SHORT_PULSE[g]),
      .long_pulse    (LONG_PULSE[g]),
      .hold          (HOLD[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table, hand-written reset/long sequences, random stimulus vs reference model.
module tb_btn_conditioner;

  localparam int CLK_FREQ = 10_000;
  localparam int DEB      = 4;
  localparam int LONG     = 30;
  localparam int TDIV     = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] BTN_RAW = 2'b00;
  logic [1:0] BTN_LVL, PRESS_PULSE, RELEASE_PULSE, SHORT_PULSE, LONG_PULSE, HOLD;
  logic       TICK_MS;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  btn_conditioner #(
    .CLK_FREQ    (CLK_FREQ),
    .DEBOUNCE_MS (DEB),
    .LONG_MS     (LONG),
    .N_BTN       (2)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .BTN_RAW       (BTN_RAW),
    .BTN_LVL       (BTN_LVL),
    .PRESS_PULSE   (PRESS_PULSE),
    .RELEASE_PULSE (RELEASE_PULSE),
    .SHORT_PULSE   (SHORT_PULSE),
    .LONG_PULSE    (LONG_PULSE),
    .HOLD          (HOLD),
    .TICK_MS       (TICK_MS)
  );

  // Reference model state: cycles since reset, raw history, per-channel tick runs and press bookkeeping.
  bit         m_valid = 1'b0;
  int         m_cyc;
  logic [1:0] m_hist[$];
  int         m_run[2];
  int         m_held[2];
  bit         m_lvl[2];
  bit         m_pressed[2];
  bit         m_long[2];
  logic [12:0] m_exp;

  // Pulse counts observed from the DUT, ch1 in [7:4], ch0 in [3:0].
  logic [7:0] c_press, c_rel, c_short, c_long;
  bit         both_press_seen;

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp_v);
    end
  endtask

  task automatic model_step();
    logic [12:0] act;
    logic [1:0]  sv;
    logic [1:0]  o_lvl, o_press, o_rel, o_short, o_long, o_hold;
    bit          tick_old, tick_new, flipped;
    act = {TICK_MS, HOLD, LONG_PULSE, SHORT_PULSE, RELEASE_PULSE, PRESS_PULSE, BTN_LVL};
    if (m_valid) begin
      checks++;
      if (act !== m_exp) begin
        errors++;
        $display("FAIL model t=%0t got %h expected %h", $time, act, m_exp);
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (PRESS_PULSE[ch] === 1'b1)   c_press = c_press + (ch == 1 ? 8'h10 : 8'h01);
      if (RELEASE_PULSE[ch] === 1'b1) c_rel   = c_rel   + (ch == 1 ? 8'h10 : 8'h01);
      if (SHORT_PULSE[ch] === 1'b1)   c_short = c_short + (ch == 1 ? 8'h10 : 8'h01);
      if (LONG_PULSE[ch] === 1'b1)    c_long  = c_long  + (ch == 1 ? 8'h10 : 8'h01);
    end
    if (PRESS_PULSE === 2'b11) both_press_seen = 1'b1;

    if (RST) begin
      m_cyc  = 0;
      m_hist = '{2'b00, 2'b00};
      for (int ch = 0; ch < 2; ch++) begin
        m_run[ch] = 0; m_held[ch] = 0; m_lvl[ch] = 0; m_pressed[ch] = 0; m_long[ch] = 0;
      end
      m_exp   = '0;
      m_valid = 1'b1;
    end else begin
      tick_old = (m_cyc > 0) && (m_cyc % TDIV == 0);
      sv = m_hist.pop_front();
      m_hist.push_back(BTN_RAW);
      m_cyc++;
      tick_new = (m_cyc % TDIV == 0);
      o_lvl = '0; o_press = '0; o_rel = '0; o_short = '0; o_long = '0; o_hold = '0;
      for (int ch = 0; ch < 2; ch++) begin
        flipped = 1'b0;
        if (sv[ch] == m_lvl[ch]) m_run[ch] = 0;
        else if (tick_old) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            flipped   = 1'b1;
            m_run[ch] = 0;
            m_lvl[ch] = sv[ch];
            if (m_lvl[ch]) begin
              o_press[ch] = 1'b1;
              m_pressed[ch] = 1'b1; m_long[ch] = 1'b0; m_held[ch] = 0;
            end else begin
              o_rel[ch]   = 1'b1;
              o_short[ch] = !m_long[ch];
              m_pressed[ch] = 1'b0; m_long[ch] = 1'b0;
            end
          end
        end
        if (!flipped && m_pressed[ch] && !m_long[ch] && tick_old) begin
          m_held[ch]++;
          if (m_held[ch] == LONG) begin
            o_long[ch] = 1'b1;
            m_long[ch] = 1'b1;
          end
        end
        o_lvl[ch]  = m_lvl[ch];
        o_hold[ch] = m_pressed[ch] && m_long[ch];
      end
      m_exp = {tick_new, o_hold, o_long, o_short, o_rel, o_press, o_lvl};
    end
  endtask

  initial forever begin
    @(negedge CLK);
    model_step();
  end

  // kind: 0 press, 1 long, 2 release, 3 tick. Samples #1 after each edge; counts ticks seen before the event.
  task automatic wait_evt(input int kind, input int ch, input int limit,
                          output int cyc, output int ticks, output bit ok);
    cyc = 0; ticks = 0; ok = 1'b0;
    while (cyc < limit && !ok) begin
      @(posedge CLK); #1;
      cyc++;
      case (kind)
        0:       ok = (PRESS_PULSE[ch] === 1'b1);
        1:       ok = (LONG_PULSE[ch] === 1'b1);
        2:       ok = (RELEASE_PULSE[ch] === 1'b1);
        default: ok = (TICK_MS === 1'b1);
      endcase
      if (!ok && TICK_MS === 1'b1) ticks++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_kind%0d_ch%0d got timeout expected event within %0d cycles", kind, ch, limit);
    end
  endtask

  task automatic clr_counts();
    c_press = '0; c_rel = '0; c_short = '0; c_long = '0;
    both_press_seen = 1'b0;
  endtask

  typedef struct {
    logic [1:0] raw;
    int         cyc;
    logic [7:0] press, rel, shrt, lng;
    logic [1:0] hold_end, lvl_end;
    bit         same;
  } vec_t;

  vec_t vt[11];

  initial begin
    int c, t, dur;
    bit ok;
    vt[0]  = '{2'b00,  30, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    vt[1]  = '{2'b01,  25, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    vt[2]  = '{2'b00,  40, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    vt[3]  = '{2'b01, 150, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 1'b0};
    vt[4]  = '{2'b00,  60, 8'h00, 8'h01, 8'h01, 8'h00, 2'b00, 2'b00, 1'b0};
    vt[5]  = '{2'b10, 500, 8'h10, 8'h00, 8'h00, 8'h10, 2'b10, 2'b10, 1'b0};
    vt[6]  = '{2'b00,  60, 8'h00, 8'h10, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    vt[7]  = '{2'b11, 150, 8'h11, 8'h00, 8'h00, 8'h00, 2'b00, 2'b11, 1'b1};
    vt[8]  = '{2'b10,  60, 8'h00, 8'h01, 8'h01, 8'h00, 2'b00, 2'b10, 1'b0};
    vt[9]  = '{2'b10, 300, 8'h00, 8'h00, 8'h00, 8'h10, 2'b10, 2'b10, 1'b0};
    vt[10] = '{2'b00,  60, 8'h00, 8'h10, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    clr_counts();

    // Reset state and tick cadence.
    RST = 1'b1; BTN_RAW = 2'b00;
    repeat (5) @(posedge CLK);
    #1;
    chk("reset_outputs", int'({TICK_MS, HOLD, LONG_PULSE, SHORT_PULSE, RELEASE_PULSE, PRESS_PULSE, BTN_LVL}), 0);
    RST = 1'b0;
    wait_evt(3, 0, 50, c, t, ok);
    chk("first_tick_delay", c, TDIV);
    wait_evt(3, 0, 50, c, t, ok);
    chk("tick_period", c, TDIV);

    for (int i = 0; i < 11; i++) begin
      clr_counts();
      BTN_RAW = vt[i].raw;
      repeat (vt[i].cyc) @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_press", i), int'(c_press), int'(vt[i].press));
      chk($sformatf("vec%0d_release", i), int'(c_rel), int'(vt[i].rel));
      chk($sformatf("vec%0d_short", i), int'(c_short), int'(vt[i].shrt));
      chk($sformatf("vec%0d_long", i), int'(c_long), int'(vt[i].lng));
      chk($sformatf("vec%0d_hold", i), int'(HOLD), int'(vt[i].hold_end));
      chk($sformatf("vec%0d_lvl", i), int'(BTN_LVL), int'(vt[i].lvl_end));
      if (vt[i].same) chk($sformatf("vec%0d_same_press", i), int'(both_press_seen), 1);
    end

    // Reset in the middle of a hold: outputs clear silently, then the hold is re-debounced.
    BTN_RAW = 2'b01;
    wait_evt(0, 0, 100, c, t, ok);
    for (int k = 0; k < 15; k++) wait_evt(3, 0, 20, c, t, ok);
    clr_counts();
    RST = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("midrst_outputs", int'({TICK_MS, HOLD, LONG_PULSE, SHORT_PULSE, RELEASE_PULSE, PRESS_PULSE, BTN_LVL}), 0);
    end
    RST = 1'b0;
    wait_evt(0, 0, 100, c, t, ok);
    chk("midrst_no_release", int'(c_rel), 0);
    chk("midrst_repress_ticks", t, DEB);
    chk("midrst_repress_cycles", c, DEB * TDIV + 1);
    wait_evt(1, 0, 400, c, t, ok);
    chk("midrst_long_ticks", t, LONG);
    chk("midrst_hold_at_long", int'(HOLD), 1);
    BTN_RAW = 2'b00;
    wait_evt(2, 0, 100, c, t, ok);
    chk("midrst_release_no_short", int'(SHORT_PULSE), 0);
    chk("midrst_hold_cleared", int'(HOLD), 0);

    // Random bounces, holds and occasional resets, checked cycle by cycle against the model.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        RST = 1'b1;
        dur = $urandom_range(1, 4);
        repeat (dur) @(posedge CLK);
        #1;
        RST = 1'b0;
      end
      dur = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 15) : $urandom_range(20, 450);
      BTN_RAW = 2'($urandom_range(0, 3));
      repeat (dur) @(posedge CLK);
      #1;
    end
    BTN_RAW = 2'b00;
    repeat (100) @(posedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the stopwatch and display front-panel logic.
- Takes N raw asynchronous push-buttons, synchronises and debounces each, and emits clean single-cycle events: press, release, short-click and long-press (hold ≥ LONG_MS).
- Consumers no longer do their own edge detection or multi-second hold counting; the stopwatch START/STOP/CLEAR/LOAD logic consumes these pulses directly.

Parameters:
- CLK_FREQ, 125_000_000: CLK frequency in Hz; the ms tick period is CLK_FREQ/1000 cycles.
- DEBOUNCE_MS, 10: number of consecutive ms ticks the input must differ from the debounced level before the level flips; must be ≥1.
- LONG_MS, 3000: ms ticks of continuous press before a long-press fires; must be > DEBOUNCE_MS.
- N_BTN, 2: number of independent button channels.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high; clock CLK.
- BTN_RAW  in  N_BTN  raw asynchronous button inputs, active-high.
- BTN_LVL  out  N_BTN  debounced button level.
- PRESS_PULSE  out  N_BTN  1-cycle pulse on debounced rising edge.
- RELEASE_PULSE  out  N_BTN  1-cycle pulse on debounced falling edge.
- SHORT_PULSE  out  N_BTN  1-cycle pulse on release when no long-press fired.
- LONG_PULSE  out  N_BTN  1-cycle pulse when hold reaches LONG_MS.
- HOLD  out  N_BTN  high from LONG_PULSE until release.
- TICK_MS  out  1  1-cycle ms strobe, exported for downstream timers.

Behaviour:
- Reset: all outputs 0, all counters 0, every channel FSM in IDLE, synchroniser flops 0.
- Tick generator:
  - counter 0..CLK_FREQ/1000-1; TICK_MS is registered high for the one cycle after the counter wraps to 0.
  - first tick occurs CLK_FREQ/1000 cycles after RST deasserts.
- Synchroniser: 2-FF per bit, so the debouncer sees BTN_RAW 2 cycles late.
- Debounce, per channel:
  - db_cnt clears whenever sync == BTN_LVL.
  - on TICK_MS with sync != BTN_LVL, db_cnt increments.
  - when db_cnt == DEBOUNCE_MS-1 at a tick with sync still differing: BTN_LVL <= sync and db_cnt <= 0.
  - Net effect: exactly DEBOUNCE_MS consecutive differing ticks are required. Any tick that sees agreement restarts the count.
- Event FSM, per channel; states IDLE, PRESSED, LONG_HELD:
  - IDLE: on the edge where BTN_LVL rises, PRESS_PULSE=1, hold_cnt <= 0, go to PRESSED.
  - PRESSED:
    - each TICK_MS increments hold_cnt.
    - at a tick with hold_cnt == LONG_MS-1: LONG_PULSE=1, HOLD=1, go to LONG_HELD.
    - BTN_LVL falls: RELEASE_PULSE=1, SHORT_PULSE=1, go to IDLE.
  - LONG_HELD: BTN_LVL falls → RELEASE_PULSE=1, HOLD=0, go to IDLE. No SHORT_PULSE. hold_cnt saturates and does not wrap.
- Timing: all pulses are registered and updated on the same clock edge as the BTN_LVL transition that causes them, so PRESS_PULSE is visible in the first cycle BTN_LVL is high.
- Simultaneous events in one channel: release and the long threshold on the same edge → release wins (RELEASE+SHORT, no LONG, HOLD stays 0).
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- hold_cnt width: $clog2(LONG_MS); db_cnt width: $clog2(DEBOUNCE_MS)+1.
- Reset mid-operation:
  - everything clears immediately, with no RELEASE_PULSE emitted.
  - a button still held after RST deasserts is re-debounced from 0 and produces a fresh PRESS_PULSE after DEBOUNCE_MS ticks.

Decomposition:
- Shared package: FSM state localparams (IDLE=2'b00, PRESSED=2'b01, LONG_HELD=2'b10) and the derived TICK_DIV = CLK_FREQ/1000.
- Sub-module btn_channel: synchroniser, debouncer and event FSM for one button. It is instantiated N_BTN times in a generate loop.
- The tick generator stays in the top level and is shared by all channels.

Test Plan (bench parameters CLK_FREQ=10_000 → tick every 10 cycles, DEBOUNCE_MS=4, LONG_MS=30, N_BTN=2):
1. Hold RST 5 cycles, BTN_RAW=0 → all outputs 0; first TICK_MS 10 cycles after RST falls, then every 10 cycles.
2. BTN_RAW[0] high for 25 cycles (≤3 ticks), then low → BTN_LVL[0] never rises; no pulses.
3. BTN_RAW[0] high for 150 cycles, then low → exactly one PRESS_PULSE[0] after the 4th tick. After release debounces: RELEASE_PULSE[0] and SHORT_PULSE[0] together, once each. LONG_PULSE[0]=0 throughout.
4. BTN_RAW[1] high for 500 cycles → PRESS_PULSE[1], then LONG_PULSE[1] exactly 30 ticks later with HOLD[1]=1. On release: RELEASE_PULSE[1] only, HOLD[1]→0, no SHORT_PULSE[1].
5. Both buttons raised in the same cycle → PRESS_PULSE[1:0]=2'b11 in the same cycle. Channel 0 is then released early (SHORT on channel 0) while channel 1 continues to LONG unaffected.
6. BTN_RAW[0] held; assert RST 3 cycles at tick 15 of the hold, keep the button high → all outputs drop to 0 with no RELEASE_PULSE. After RST: PRESS_PULSE[0] again after 4 ticks, and LONG after 30 more ticks.
